// File: rtl/conv_sa_accum_pkg.sv
// Shared widths, state type and helpers for the systolic conv column accumulator.
package conv_sa_accum_pkg;

   localparam int unsigned conv16_width = 16;
   localparam int unsigned DATA_W       = 2 * conv16_width;
   localparam int unsigned N_COL        = 14;
   localparam int unsigned ACC_W        = DATA_W + 4;
   localparam int unsigned IDX_W        = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Sign-extend a column sum or bias to accumulator width
   function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] v);
      return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

endpackage

// File: rtl/conv_sat_relu.sv
// Saturates an accumulator to result width, then optionally clamps negatives to zero.
module conv_sat_relu
   import conv_sa_accum_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc_i,
   input  logic                     relu_i,
   output logic signed [DATA_W-1:0] sat_c_o
);

   logic [ACC_W-DATA_W:0] top_bits_c;

   always_comb begin
      top_bits_c = acc_i[ACC_W-1:DATA_W-1];
      if ((top_bits_c == '0) || (top_bits_c == '1)) begin
         sat_c_o = acc_i[DATA_W-1:0];
      end else if (acc_i[ACC_W-1]) begin
         sat_c_o = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat_c_o = {1'b0, {(DATA_W-1){1'b1}}};
      end
      if (relu_i && sat_c_o[DATA_W-1]) begin
         sat_c_o = '0;
      end
   end

endmodule

// File: rtl/conv_sa_accum.sv
// Accumulates 14 conv-core column sums over input channels and drains
// saturated (optionally ReLU'd) results one column per handshake.
module conv_sa_accum
   import conv_sa_accum_pkg::*;
(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en,
   input  logic                     i_sum_vld,
   input  logic signed [DATA_W-1:0] i_sum1,
   input  logic signed [DATA_W-1:0] i_sum2,
   input  logic signed [DATA_W-1:0] i_sum3,
   input  logic signed [DATA_W-1:0] i_sum4,
   input  logic signed [DATA_W-1:0] i_sum5,
   input  logic signed [DATA_W-1:0] i_sum6,
   input  logic signed [DATA_W-1:0] i_sum7,
   input  logic signed [DATA_W-1:0] i_sum8,
   input  logic signed [DATA_W-1:0] i_sum9,
   input  logic signed [DATA_W-1:0] i_sum10,
   input  logic signed [DATA_W-1:0] i_sum11,
   input  logic signed [DATA_W-1:0] i_sum12,
   input  logic signed [DATA_W-1:0] i_sum13,
   input  logic signed [DATA_W-1:0] i_sum14,
   input  logic                     i_first,
   input  logic                     i_last,
   input  logic signed [DATA_W-1:0] i_bias,
   input  logic                     i_relu_en,
   output logic signed [DATA_W-1:0] o_data,
   output logic [IDX_W-1:0]         o_idx,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic                     o_busy,
   output logic                     o_err
);

   state_e                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q [N_COL];
   logic signed [ACC_W-1:0]   acc_d [N_COL];
   logic signed [DATA_W-1:0]  sum_c [N_COL];
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      relu_q, relu_d;
   logic                      valid_q, valid_d;
   logic                      busy_q, busy_d;
   logic                      err_q, err_d;
   logic signed [DATA_W-1:0]  data_q, data_d;
   logic signed [ACC_W-1:0]   sel_acc_c;
   logic signed [DATA_W-1:0]  sat_c;
   logic                      beat_c, hs_c;

   always_comb begin
      sum_c[0]  = i_sum1;   sum_c[1]  = i_sum2;   sum_c[2]  = i_sum3;
      sum_c[3]  = i_sum4;   sum_c[4]  = i_sum5;   sum_c[5]  = i_sum6;
      sum_c[6]  = i_sum7;   sum_c[7]  = i_sum8;   sum_c[8]  = i_sum9;
      sum_c[9]  = i_sum10;  sum_c[10] = i_sum11;  sum_c[11] = i_sum12;
      sum_c[12] = i_sum13;  sum_c[13] = i_sum14;
   end

   // Next-state: accept beats outside DRAIN, step the drain index on handshakes
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      relu_d  = relu_q;
      valid_d = valid_q;
      err_d   = err_q;
      beat_c  = en && i_sum_vld && (state_q != DRAIN);
      hs_c    = en && valid_q && i_ready;

      if (en && i_sum_vld && (state_q == DRAIN)) begin
         err_d = 1'b1;
      end

      if (beat_c) begin
         for (int unsigned k = 0; k < N_COL; k++) begin
            acc_d[k] = (i_first ? sext(i_bias) : acc_q[k]) + sext(sum_c[k]);
         end
         if (i_last) begin
            state_d = DRAIN;
            relu_d  = i_relu_en;
            idx_d   = '0;
            valid_d = 1'b1;
         end else begin
            state_d = ACCUM;
         end
      end

      if (hs_c) begin
         if (idx_q == IDX_W'(N_COL - 1)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            for (int unsigned k = 0; k < N_COL; k++) begin
               acc_d[k] = '0;
            end
         end else begin
            idx_d = IDX_W'(idx_q + IDX_W'(1));
         end
      end
   end

   // Result is computed from the next-cycle column so it lines up with o_idx
   assign sel_acc_c = acc_d[idx_d];

   conv_sat_relu u_sat_relu (
      .acc_i   (sel_acc_c),
      .relu_i  (relu_d),
      .sat_c_o (sat_c)
   );

   always_comb begin
      busy_d = (state_d == DRAIN);
      data_d = (en && (state_d == DRAIN)) ? sat_c : data_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         for (int unsigned k = 0; k < N_COL; k++) begin
            acc_q[k] <= '0;
         end
         idx_q   <= '0;
         relu_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         relu_q  <= relu_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign o_data  = data_q;
   assign o_idx   = idx_q;
   assign o_valid = valid_q;
   assign o_busy  = busy_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_conv_sa_accum.sv
// Randomized and directed bench for conv_sa_accum against a per-tile arithmetic model.
module tb_conv_sa_accum;
   import conv_sa_accum_pkg::*;

   localparam int     NC   = 14;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic                     clk, rstn, en, i_sum_vld, i_first, i_last, i_relu_en, i_ready;
   logic signed [DATA_W-1:0] s [NC];
   logic signed [DATA_W-1:0] bias_s;
   logic signed [DATA_W-1:0] o_data;
   logic [IDX_W-1:0]         o_idx;
   logic                     o_valid, o_busy, o_err;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint m_acc [NC];
   bit     m_relu;

   conv_sa_accum dut (
      .clk(clk), .rstn(rstn), .en(en), .i_sum_vld(i_sum_vld),
      .i_sum1(s[0]),   .i_sum2(s[1]),   .i_sum3(s[2]),   .i_sum4(s[3]),
      .i_sum5(s[4]),   .i_sum6(s[5]),   .i_sum7(s[6]),   .i_sum8(s[7]),
      .i_sum9(s[8]),   .i_sum10(s[9]),  .i_sum11(s[10]), .i_sum12(s[11]),
      .i_sum13(s[12]), .i_sum14(s[13]),
      .i_first(i_first), .i_last(i_last), .i_bias(bias_s), .i_relu_en(i_relu_en),
      .o_data(o_data), .o_idx(o_idx), .o_valid(o_valid), .i_ready(i_ready),
      .o_busy(o_busy), .o_err(o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // 36-bit two's complement wrap of the model accumulators
   function automatic longint wrap36(input longint v);
      longint x;
      x = v <<< 28;
      return x >>> 28;
   endfunction

   function automatic longint exp_out(input int k);
      longint v;
      v = m_acc[k];
      if (v > SMAX) v = SMAX;
      else if (v < SMIN) v = SMIN;
      if (m_relu && v < 0) v = 0;
      return v;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NC; k++) m_acc[k] = 0;
   endtask

   task automatic set_sums(input int pat, input longint val);
      for (int k = 0; k < NC; k++) begin
         case (pat)
            0:       s[k] = DATA_W'(10 * (k + 1));
            1:       s[k] = DATA_W'(val);
            2:       s[k] = DATA_W'($urandom);
            default: s[k] = DATA_W'(int'($urandom_range(0, 2000)) - 1000);
         endcase
      end
   endtask

   task automatic beat(input bit first, input bit last, input longint bias, input bit relu);
      en        = 1'b1;
      i_sum_vld = 1'b1;
      i_first   = first;
      i_last    = last;
      i_relu_en = relu;
      bias_s    = DATA_W'(bias);
      for (int k = 0; k < NC; k++) begin
         m_acc[k] = wrap36((first ? longint'(bias_s) : m_acc[k]) + longint'(s[k]));
      end
      if (last) m_relu = relu;
      @(negedge clk);
      i_sum_vld = 1'b0;
      i_first   = 1'b0;
      i_last    = 1'b0;
   endtask

   // mode 0: ready always high; 1: ready alternating plus a dropped beat; 2: random ready/en
   task automatic drain(input int mode, input int stop_at);
      int got = 0;
      int cyc = 0;
      bit r, e, stop;
      stop = 1'b0;
      chk("valid_t1", o_valid, 1);
      chk("idx_t1", o_idx, 0);
      while (got < NC && cyc < 200 && !stop) begin
         if (stop_at >= 0 && got == stop_at) begin
            chk("idx_pre_rst", o_idx, stop_at);
            rstn = 1'b0;
            #1;
            chk("rst_valid", o_valid, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_idx", o_idx, 0);
            chk("rst_data", o_data, 0);
            model_clear();
            m_relu = 1'b0;
            i_ready = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            @(negedge clk);
            chk("post_rst_valid", o_valid, 0);
            return;
         end
         if (!o_valid) begin
            chk("valid_drop", o_valid, 1);
            stop = 1'b1;
         end else begin
            chk("idx", o_idx, got);
            chk("data", o_data, exp_out(got));
            chk("busy", o_busy, 1);
            case (mode)
               0:       begin r = 1'b1; e = 1'b1; end
               1:       begin r = (cyc % 2 == 0); e = 1'b1; end
               default: begin r = 1'($urandom_range(0, 1)); e = ($urandom_range(0, 3) != 0); end
            endcase
            i_ready = r;
            en      = e;
            if (mode == 1 && cyc == 1) begin
               set_sums(2, 0);
               i_sum_vld = 1'b1;
            end else begin
               i_sum_vld = 1'b0;
            end
            if (r && e) got++;
            @(negedge clk);
            cyc++;
         end
      end
      i_ready   = 1'b0;
      en        = 1'b1;
      i_sum_vld = 1'b0;
      if (got < NC) chk("drain_handshakes", got, NC);
      if (mode == 1) chk("bp_cycles", cyc, 27);
      chk("done_valid", o_valid, 0);
      chk("done_busy", o_busy, 0);
      model_clear();
   endtask

   task automatic tile(input int nch, input bit use_first, input longint bias, input bit relu,
                       input int pat, input longint val, input int mode, input int stop_at);
      for (int ch = 0; ch < nch; ch++) begin
         set_sums(pat, val);
         beat(use_first && ch == 0, ch == nch - 1, bias, relu);
      end
      drain(mode, stop_at);
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; i_sum_vld = 1'b0; i_first = 1'b0; i_last = 1'b0;
      i_relu_en = 1'b0; i_ready = 1'b0; bias_s = '0;
      for (int k = 0; k < NC; k++) s[k] = '0;
      model_clear();
      m_relu = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid0", o_valid, 0);
      chk("rst_busy0", o_busy, 0);
      chk("rst_err0", o_err, 0);
      chk("rst_idx0", o_idx, 0);
      chk("rst_data0", o_data, 0);
      rstn = 1'b1;
      en   = 1'b1;
      @(negedge clk);

      tile(1, 1'b1, 5, 1'b0, 0, 0, 0, -1);
      tile(3, 1'b1, -50, 1'b0, 1, 100, 0, -1);
      tile(1, 1'b1, -1000, 1'b1, 1, 10, 0, -1);
      tile(1, 1'b1, -1000, 1'b0, 1, 10, 0, -1);

      chk("err_before_bp", o_err, 0);
      tile(2, 1'b1, 7, 1'b0, 3, 0, 1, -1);
      chk("err_after_bp", o_err, 1);

      tile(16, 1'b1, 0, 1'b0, 1, 64'h7FFF_FFFF, 0, -1);
      tile(16, 1'b1, 0, 1'b0, 1, 64'h8000_0000, 0, -1);

      tile(2, 1'b1, 123, 1'b0, 3, 0, 0, 6);
      chk("err_after_rst", o_err, 0);
      tile(1, 1'b1, 0, 1'b0, 1, 1, 0, -1);

      for (int t = 0; t < 10; t++) begin
         tile(int'($urandom_range(1, 4)), ($urandom_range(0, 3) != 0), longint'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(2, 3)), 0, 2, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
